// File: rtl/enc_pkg.sv
// Shared definitions for the 4-to-2 sequential priority encoder.
// Holds default request count, index width and the index type.
package enc_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int IDX_W_DEF = $clog2(N_REQ_DEF);

  typedef logic [IDX_W_DEF-1:0] idx_t;

endpackage

// File: rtl/enc_4x2_seq_prio_pick.sv
// prio_pick: combinational picker, first set bit of vec at or after base.
// Ports: vec (candidates), base (start index), idx (winner), found.
module prio_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] base,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest
  // candidate to base is the last one written; N is a power
  // of two, so W-bit addition wraps naturally.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int o = N - 1; o >= 0; o--) begin
      pos = base + W'(o);
      if (vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc_4x2_seq.sv
// enc_4x2_seq: registered priority encoder, active-low requests in,
// one index per valid/ready handshake out. ENC_ROUND_ROBIN_EN selects
// a rotating search start; default build is fixed priority (index 0).
// Ports: clk, rst (sync, active-high), en (active-low capture enable),
// req_n (active-low requests), code_out, valid, ready, busy.
module enc_4x2_seq
  import enc_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req_n,
  output logic [IDX_W-1:0] code_out,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] pending_nx;
  logic [N_REQ-1:0] cap;
  logic [N_REQ-1:0] hold_m;
  logic [N_REQ-1:0] load_m;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             load_ok;
  logic             do_load;
  logic             accept;

  assign load_ok = !valid || ready;
  assign accept  = valid && ready;
  assign do_load = load_ok && pick_found;

`ifdef ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= code_out + 1'b1;
    end
  end

  assign base = ptr;
`else
  assign base = '0;
`endif

  prio_pick #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_pick (
    .vec   (pending),
    .base  (base),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // A held line is masked so a level request only re-queues
  // after its grant has been accepted; the line being loaded
  // is masked so it is not immediately re-pended.
  always_comb begin
    hold_m = '0;
    load_m = '0;
    if (valid) begin
      hold_m[code_out] = 1'b1;
    end
    if (do_load) begin
      load_m[pick_idx] = 1'b1;
    end
    cap        = en ? '0 : ~req_n;
    pending_nx = (pending & ~load_m)
               | (cap & ~hold_m & ~load_m);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      valid    <= 1'b0;
      code_out <= '0;
    end else begin
      pending <= pending_nx;
      if (load_ok) begin
        valid <= pick_found;
        if (pick_found) begin
          code_out <= pick_idx;
        end
      end
    end
  end

  assign busy = (|pending) | valid;

endmodule
